// File: rtl/sram_pkg.sv
// Shared types for the SRAM read-capture path.
// Access-size encodings and the in-flight read tag.
package sram_pkg;

  typedef enum logic [1:0] {
    CONF_WORD = 2'b00,
    CONF_HALF = 2'b01,
    CONF_BYTE = 2'b10,
    CONF_RSVD = 2'b11
  } conf_e;

  typedef struct packed {
    logic       valid;
    conf_e      conf;
    logic [1:0] off;
  } tag_t;

  localparam tag_t TAG_IDLE = '{
    valid: 1'b0,
    conf:  CONF_WORD,
    off:   2'b00
  };

endpackage

// File: rtl/sram_resp_fifo.sv
// Response FIFO for the SRAM read-capture path.
// Synchronous, power-of-two depth, sync active-low reset.
module sram_resp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              sram_clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_pop;
  logic              do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  // pointer and occupancy tracking
  always_ff @(posedge sram_clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // storage array, no reset needed: guarded by count
  always_ff @(posedge sram_clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/sram_read_capture.sv
// Tracks SRAM reads, captures macro data after READ_LAT,
// formats sub-words and returns them via valid/ready.
module sram_read_capture
  import sram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1,
  parameter int DEPTH    = 4
) (
  input  logic              sram_clk,
  input  logic              rst_n,
  input  logic              csb_sync,
  input  logic              web_sync,
  input  logic [ADDR_W-1:0] addr_sync,
  input  logic [1:0]        conf_sync,
  input  logic [DATA_W-1:0] macro_dout,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              stall,
  output logic              overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  tag_t              pipe [READ_LAT];
  tag_t              issue;
  tag_t              tail;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] fmt_data;
  logic [DATA_W-1:0] half_sh;
  logic [DATA_W-1:0] byte_sh;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              unused_addr;

  assign unused_addr = ^addr_sync[ADDR_W-1:2];

  // build the tag for this cycle's access
  always_comb begin
    issue       = TAG_IDLE;
    issue.valid = !csb_sync && web_sync;
    issue.conf  = conf_e'(conf_sync);
    issue.off   = addr_sync[1:0];
  end

  // READ_LAT-deep tag shift pipeline
  always_ff @(posedge sram_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++)
        pipe[i] <= TAG_IDLE;
    end else begin
      pipe[0] <= issue;
      for (int i = 1; i < READ_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[READ_LAT-1];

  // number of reads still waiting on macro data
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++)
      inflight = inflight + CW'(pipe[i].valid);
  end

  // sub-word extraction of returning macro data
  always_comb begin
    half_sh  = macro_dout >> {tail.off[1], 4'b0000};
    byte_sh  = macro_dout >> {tail.off, 3'b000};
    fmt_data = macro_dout;
    unique case (1'b1)
      (tail.conf == CONF_HALF):
        fmt_data = DATA_W'(half_sh[15:0]);
      (tail.conf == CONF_BYTE):
        fmt_data = DATA_W'(byte_sh[7:0]);
      default:
        fmt_data = macro_dout;
    endcase
  end

  assign push       = tail.valid;
  assign pop        = dout_valid && dout_ready;
  assign dout_valid = !empty;

  sram_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .sram_clk (sram_clk),
    .rst_n    (rst_n),
    .push     (push),
    .wdata    (fmt_data),
    .pop      (pop),
    .rdata    (dout),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // sticky flag for a capture lost to a full FIFO
  always_ff @(posedge sram_clk) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (push && full && !pop)
      overflow <= 1'b1;
  end

  assign stall =
    ({1'b0, count} + {1'b0, inflight}) >= (CW+1)'(DEPTH);

endmodule
